// File: rtl/lu_pkg.sv
// lu_pkg: logic_unit op encodings and result-buffer state shared by the arbiter, logic unit and bench
package lu_pkg;
  localparam int LU_CTL_W = 3;
  localparam logic [LU_CTL_W-1:0] LU_AND  = 3'd0;
  localparam logic [LU_CTL_W-1:0] LU_OR   = 3'd1;
  localparam logic [LU_CTL_W-1:0] LU_XOR  = 3'd2;
  localparam logic [LU_CTL_W-1:0] LU_NOR  = 3'd3;
  localparam logic [LU_CTL_W-1:0] LU_NAND = 3'd4;
  localparam logic [LU_CTL_W-1:0] LU_XNOR = 3'd5;
  localparam logic [LU_CTL_W-1:0] LU_ANDN = 3'd6;
  localparam logic [LU_CTL_W-1:0] LU_NOTA = 3'd7;
  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} buf_state_t;
endpackage

// File: rtl/logic_unit.sv
// logic_unit: combinational bitwise op on a_i/b_i selected by ctl_i; y_o is the result
module logic_unit
  import lu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]    a_i,
  input  logic [WIDTH-1:0]    b_i,
  input  logic [LU_CTL_W-1:0] ctl_i,
  output logic [WIDTH-1:0]    y_o
);
  always_comb
    y_o = ctl_i == LU_AND  ? a_i & b_i :
          ctl_i == LU_OR   ? a_i | b_i :
          ctl_i == LU_XOR  ? a_i ^ b_i :
          ctl_i == LU_NOR  ? ~(a_i | b_i) :
          ctl_i == LU_NAND ? ~(a_i & b_i) :
          ctl_i == LU_XNOR ? ~(a_i ^ b_i) :
          ctl_i == LU_ANDN ? a_i & ~b_i : ~a_i;
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick of the first set req_i bit starting at ptr_i
// ports: req_i request vector, ptr_i search start, en_i grant enable,
//        gnt_o one-hot grant, idx_o grant index, any_o a grant is issued
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  input  logic            en_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);
  logic [IDW-1:0] j;
  // scanning from the far end backwards leaves the nearest requester in idx_o
  always_comb begin
    idx_o = ptr_i;
    j = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = IDW'((int'(ptr_i) + k) % NREQ);
      if (req_i[j]) idx_o = j;
    end
    any_o = en_i & |req_i;
    gnt_o = any_o ? NREQ'(1) << idx_o : '0;
  end
endmodule

// File: rtl/lu_arbiter.sv
// lu_arbiter: round-robin share of one logic_unit among NREQ requesters with a one-entry result buffer
// ports: clk, rst (sync, active-high); req_valid/req_ready/req_a/req_b/req_ctl per-requester issue;
//        res_valid/res_ready/res_data/res_id result drain
// optional LU_ARB_STATS_EN: stat_clr input and stat_cnt saturating per-requester transfer counters
module lu_arbiter
  import lu_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 32,
`ifdef LU_ARB_STATS_EN
  parameter  int CNTW  = 16,
`endif
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*WIDTH-1:0]    req_a,
  input  logic [NREQ*WIDTH-1:0]    req_b,
  input  logic [NREQ*LU_CTL_W-1:0] req_ctl,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [WIDTH-1:0]         res_data,
  output logic [IDW-1:0]           res_id
`ifdef LU_ARB_STATS_EN
  ,
  input  logic                     stat_clr,
  output logic [NREQ*CNTW-1:0]     stat_cnt
`endif
);
  buf_state_t state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d, id_q, id_d, gidx;
  logic [WIDTH-1:0] data_q, data_d, sel_a, sel_b, lu_y;
  logic [LU_CTL_W-1:0] sel_ctl;
  logic xfer;
  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .en_i  (!rst && (state_q == ST_EMPTY || res_ready)),
    .gnt_o (req_ready),
    .idx_o (gidx),
    .any_o (xfer)
  );
  always_comb begin
    sel_a   = req_a[gidx*WIDTH +: WIDTH];
    sel_b   = req_b[gidx*WIDTH +: WIDTH];
    sel_ctl = req_ctl[gidx*LU_CTL_W +: LU_CTL_W];
  end
  logic_unit #(.WIDTH(WIDTH)) u_lu (
    .a_i   (sel_a),
    .b_i   (sel_b),
    .ctl_i (sel_ctl),
    .y_o   (lu_y)
  );
  always_comb begin
    state_d = xfer ? ST_FULL : res_ready ? ST_EMPTY : state_q;
    ptr_d   = xfer ? (gidx == IDW'(NREQ - 1) ? '0 : gidx + 1'b1) : ptr_q;
    data_d  = xfer ? lu_y : data_q;
    id_d    = xfer ? gidx : id_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      ptr_q   <= '0;
      data_q  <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      id_q    <= id_d;
    end
  end
  assign res_valid = state_q == ST_FULL;
  assign res_data  = data_q;
  assign res_id    = id_q;
`ifdef LU_ARB_STATS_EN
  logic [NREQ*CNTW-1:0] cnt_q, cnt_d;
  // clear takes priority over a same-cycle transfer
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NREQ; i++)
      if (req_ready[i] && !(&cnt_q[i*CNTW +: CNTW])) cnt_d[i*CNTW +: CNTW] = cnt_q[i*CNTW +: CNTW] + 1'b1;
    if (stat_clr) cnt_d = '0;
  end
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign stat_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_lu_arbiter.sv
// tb_lu_arbiter: scoreboard bench for lu_arbiter with an independent grant/result model
module tb_lu_arbiter;
  typedef struct {logic [31:0] a; logic [31:0] b; logic [2:0] ctl;} op_t;
  typedef struct {logic [1:0] id; logic [31:0] data;} res_t;
  logic clk = 0, rst = 1, res_ready = 1, flood = 0;
  logic [3:0] req_valid, req_ready, cur_v;
  logic [127:0] req_a, req_b;
  logic [11:0] req_ctl;
  logic res_valid;
  logic [31:0] res_data;
  logic [1:0] res_id;
  logic [31:0] cur_a[4], cur_b[4];
  logic [2:0] cur_ctl[4];
  op_t op_q[4][$];
  res_t sb[$];
  int glog[$], gcyc[$];
  int n_cmp = 0, n_err = 0, cyc = 0, m_ptr = 0;
  logic m_full = 0;
`ifdef LU_ARB_STATS_EN
  logic stat_clr = 0;
  logic [63:0] stat_cnt;
  logic [15:0] m_cnt[4];
`endif
  always #5 clk = ~clk;
  assign req_valid = cur_v;
  assign req_a = {cur_a[3], cur_a[2], cur_a[1], cur_a[0]};
  assign req_b = {cur_b[3], cur_b[2], cur_b[1], cur_b[0]};
  assign req_ctl = {cur_ctl[3], cur_ctl[2], cur_ctl[1], cur_ctl[0]};
  lu_arbiter #(.NREQ(4), .WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_ctl(req_ctl),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id)
`ifdef LU_ARB_STATS_EN
    , .stat_clr(stat_clr), .stat_cnt(stat_cnt)
`endif
  );
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic logic [31:0] golden(logic [31:0] a, logic [31:0] b, logic [2:0] c);
    case (c)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a | b);
      3'd4: return ~(a & b);
      3'd5: return ~(a ^ b);
      3'd6: return a & ~b;
      default: return ~a;
    endcase
  endfunction
  function automatic int rr_pick(logic [3:0] v, int p);
    for (int k = 0; k < 4; k++) if (v[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction
  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      cur_v[i]   = op_q[i].size() > 0 || (i == 0 && flood);
      cur_a[i]   = op_q[i].size() > 0 ? op_q[i][0].a : 32'h0;
      cur_b[i]   = op_q[i].size() > 0 ? op_q[i][0].b : 32'h0;
      cur_ctl[i] = op_q[i].size() > 0 ? op_q[i][0].ctl : 3'h0;
    end
  endtask
  initial forever begin
    @(posedge clk);
    #1 drive();
  end
  // model: expected grant from own pointer/buffer state; results pushed at grant, popped at drain
  always @(negedge clk) begin
    int g;
    logic [3:0] ge;
    cyc++;
    g = (rst || (m_full && !res_ready)) ? -1 : rr_pick(req_valid, m_ptr);
    ge = g < 0 ? 4'b0 : 4'b1 << g;
    chk("req_ready", req_ready, ge);
    chk("res_valid", res_valid, m_full);
    if (m_full && sb.size() > 0) begin
      chk("res_id", res_id, sb[0].id);
      chk("res_data", res_data, sb[0].data);
    end
`ifdef LU_ARB_STATS_EN
    chk("stat_cnt", stat_cnt, {m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]});
`endif
    for (int i = 0; i < 4; i++)
      if (req_valid[i] && req_ready[i]) begin
        glog.push_back(i);
        gcyc.push_back(cyc);
        if (op_q[i].size() > 0) void'(op_q[i].pop_front());
      end
    if (rst) begin
      m_full = 0;
      m_ptr = 0;
      sb.delete();
`ifdef LU_ARB_STATS_EN
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
`endif
    end else begin
      if (m_full && res_ready && sb.size() > 0) begin
        void'(sb.pop_front());
        m_full = 0;
      end
      if (g >= 0) begin
        sb.push_back('{id: 2'(g), data: golden(cur_a[g], cur_b[g], cur_ctl[g])});
        m_full = 1;
        m_ptr = (g + 1) % 4;
      end
`ifdef LU_ARB_STATS_EN
      if (stat_clr) for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      else if (g >= 0 && m_cnt[g] != 16'hFFFF) m_cnt[g]++;
`endif
    end
  end
  task automatic wait_idle();
    int n = 0;
    do begin
      @(posedge clk);
      #2 n++;
    end while ((op_q[0].size() + op_q[1].size() + op_q[2].size() + op_q[3].size() != 0 || res_valid) && n < 300);
    chk("idle_timeout", n >= 300, 0);
  endtask
  task automatic wait_full();
    int n = 0;
    do begin
      @(posedge clk);
      #2 n++;
    end while (!res_valid && n < 50);
    chk("full_timeout", n >= 50, 0);
  endtask
  task automatic check_log(string tag, input int exp[$]);
    chk({tag, "_n"}, glog.size(), exp.size());
    foreach (exp[k]) if (k < glog.size()) chk(tag, glog[k], exp[k]);
    glog.delete();
    gcyc.delete();
  endtask
  initial begin
    int cnt;
    for (int i = 0; i < 4; i++) op_q[i].push_back('{a: 32'h1000 + i, b: 32'h0F0F_0F0F, ctl: 3'(i)});
`ifdef LU_ARB_STATS_EN
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
`endif
    drive();
    @(posedge clk);
    #2;
    chk("rst_ready", req_ready, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_data", res_data, 0);
    chk("rst_id", res_id, 0);
    @(posedge clk);
    #1 rst = 0;
    wait_idle();
    check_log("rst_order", '{0, 1, 2, 3});
    for (int k = 0; k < 8; k++) op_q[2].push_back('{a: 32'h26, b: 32'h0, ctl: 3'(k)});
    wait_idle();
    chk("sweep_span", gcyc.size() > 0 ? gcyc[gcyc.size()-1] - gcyc[0] : -1, 7);
    check_log("sweep", '{2, 2, 2, 2, 2, 2, 2, 2});
    op_q[3].push_back('{a: 32'hA5A5_5A5A, b: 32'hFFFF_0000, ctl: 3'd2});
    wait_idle();
    check_log("to_ptr0", '{3});
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < 4; i++) op_q[i].push_back('{a: $urandom, b: $urandom, ctl: 3'($urandom_range(0, 7))});
    wait_idle();
    chk("fair_span", gcyc.size() > 0 ? gcyc[gcyc.size()-1] - gcyc[0] : -1, 11);
    for (int i = 0; i < 4; i++) begin
      cnt = 0;
      foreach (glog[k]) if (glog[k] == i) cnt++;
      chk("fair_count", cnt, 3);
    end
    check_log("fair", '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3});
    res_ready = 0;
    op_q[1].push_back('{a: 32'hDEAD_BEEF, b: 32'h00FF_00FF, ctl: 3'd6});
    wait_full();
    for (int i = 0; i < 4; i++) op_q[i].push_back('{a: 32'h100 * (i + 1), b: 32'h3C3C_3C3C, ctl: 3'd1});
    repeat (5) begin
      @(posedge clk);
      #2;
      chk("bp_ready", req_ready, 0);
      chk("bp_id", res_id, 1);
      chk("bp_data", res_data, 32'hDE00_BE00);
    end
    res_ready = 1;
    @(posedge clk);
    #2 chk("bp_next_id", res_id, 2);
    wait_idle();
    check_log("bp", '{1, 2, 3, 0, 1});
    op_q[1].push_back('{a: 32'h1111_1111, b: 32'h2222_2222, ctl: 3'd3});
    op_q[3].push_back('{a: 32'h3333_3333, b: 32'h4444_4444, ctl: 3'd4});
    wait_idle();
    check_log("skip_wrap", '{3, 1});
    res_ready = 0;
    op_q[0].push_back('{a: 32'hFFFF_0000, b: 32'h0F0F_0F0F, ctl: 3'd0});
    wait_full();
    rst = 1;
    @(posedge clk);
    #2 chk("mid_rst_valid", res_valid, 0);
    rst = 0;
    res_ready = 1;
    op_q[0].push_back('{a: 32'h1234_5678, b: 32'h8765_4321, ctl: 3'd5});
    op_q[2].push_back('{a: 32'h0BAD_F00D, b: 32'hFACE_CAFE, ctl: 3'd7});
    wait_idle();
    check_log("post_rst", '{0, 0, 2});
`ifdef LU_ARB_STATS_EN
    flood = 1;
    repeat (70000) @(posedge clk);
    #2 chk("stat_sat", stat_cnt[15:0], 16'hFFFF);
    stat_clr = 1;
    @(posedge clk);
    #2 chk("stat_clr", stat_cnt, 0);
    stat_clr = 0;
    flood = 0;
    wait_idle();
    glog.delete();
    gcyc.delete();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/lu_arbiter.md
Name: lu_arbiter

Overview:
- Shares one 32-bit logic_unit between NREQ requesters using a round-robin grant.
- Each requester presents operands a, b and a 3-bit ctl under a valid/ready handshake.
- The granted operation is evaluated by an internal logic_unit instance.
- The result is registered into a one-entry output buffer, tagged with the requester id, and drained under its own valid/ready handshake.
- Sits between CPU-side issue ports and the shared logic datapath.

Parameters:
- NREQ, 4: number of requesters (2..8).
- WIDTH, 32: operand/result width; must match logic_unit.
- IDW, $clog2(NREQ): requester id width (derived, localparam).
- CNTW, 16: statistics counter width (used only with LU_ARB_STATS_EN).

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  requester i has an operation pending.
- req_ready  out  NREQ  one-hot grant; transfer on req_valid[i] & req_ready[i].
- req_a  in  NREQ*WIDTH  operand a, slice i = [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand b, same slicing.
- req_ctl  in  NREQ*3  logic_unit op select, slice [i*3 +: 3].
- res_valid  out  1  result buffer full.
- res_ready  in  1  consumer accepts result.
- res_data  out  WIDTH  logic_unit output for the accepted operation.
- res_id  out  IDW  index of the requester that issued it.

Behaviour:
- Output buffer FSM, two states:
  - EMPTY: res_valid=0.
  - FULL: res_valid=1.
- Accept condition: can_accept = EMPTY | (FULL & res_ready).
- Grant:
  - When can_accept=1, req_ready is one-hot on the first i with req_valid[i]=1, searching ptr, ptr+1, …, NREQ-1, 0, …, ptr-1 (modulo NREQ).
  - When can_accept=0 or no req_valid is set, req_ready is all zero.
- req_ready is combinational from req_valid, ptr and buffer state. It never depends on res_data.
- On a transfer from requester g:
  - res_data <= logic_unit(req_a[g], req_b[g], req_ctl[g]).
  - res_id <= g.
  - state <= FULL.
  - ptr <= (g+1) mod NREQ.
- FULL & res_ready & no transfer: state <= EMPTY. res_data and res_id hold their last values.
- FULL & res_ready & transfer: drain and refill in the same cycle. Sustained throughput is 1 op/clk.
- FULL & !res_ready: res_data, res_id and res_valid are stable, and all req_ready are 0.
- Latency: a request accepted in cycle n is visible on res_* in cycle n+1.
- Requester rules:
  - Must hold a/b/ctl stable while valid and not granted.
  - May drop valid before grant; no op is lost or duplicated.
- ptr advances only on a transfer. Idle cycles do not rotate priority.
- Reset (any cycle, including with res_valid=1):
  - state=EMPTY, res_valid=0, res_data=0, res_id=0, ptr=0.
  - req_ready=0 while rst=1.
  - An in-flight result is discarded.
- Wrap-around: grant to NREQ-1 sets ptr=0.
- Non-power-of-two NREQ:
  - The modulo is explicit.
  - Unused id encodings are never produced.

Optional Feature:
- Macro: LU_ARB_STATS_EN.
- With it defined:
  - Adds output stat_cnt (NREQ*CNTW) and input stat_clr (1).
  - Counter i increments on each transfer from requester i and saturates at all-ones.
  - stat_clr=1 zeroes all counters. If a transfer occurs in the same cycle, the clear wins.
  - rst zeroes all counters.
- Without it: no stat_cnt/stat_clr ports and no counter logic. All other behaviour is identical.

Decomposition:
- Shared package lu_pkg holds:
  - LU_CTL_W = 3.
  - logic_unit ctl encodings as named constants, shared with the existing logic unit and bench.
  - The buffer state typedef {ST_EMPTY, ST_FULL}.
- One natural sub-module, rr_arbiter (NREQ):
  - Inputs: req vector, ptr, enable.
  - Outputs: one-hot grant, binary grant index, any_grant.
- logic_unit is instantiated unchanged.

Test Plan:
- Reset:
  - Stimulus: rst=1 for 2 clks with req_valid=4'b1111, res_ready=1.
  - Response: req_ready=0, res_valid=0, res_data=0, res_id=0. After release, the first grant is to requester 0.
- Single requester sweep:
  - Stimulus: requester 2, a=32'h00000026, b=0, ctl stepping 000..111 on consecutive grants, res_ready=1.
  - Response: 8 results in 8 consecutive cycles, each one cycle after its grant, res_id=2. res_data equals a golden logic_unit fed the same inputs.
- Fairness:
  - Stimulus: all 4 req_valid held high, res_ready=1, 12 cycles.
  - Response: grant order 0,1,2,3,0,1,2,3,0,1,2,3, exactly 3 grants per requester.
- Backpressure:
  - Stimulus: buffer FULL with res_id=1, res_ready=0 for 5 clks, req_valid=4'b1111.
  - Response: req_ready=0 and res_data/res_id stable throughout. The cycle res_ready rises, the buffer drains and requester 2 is granted; res_id=2 on the next cycle.
- Skip and wrap:
  - Stimulus: ptr=2, req_valid=4'b1010.
  - Response: grant 3 first, then 1, then ptr=2.
- Reset mid-operation and stats (with LU_ARB_STATS_EN):
  - Stimulus: rst pulsed while res_valid=1; separately, requester 0 granted 70000 times, then stat_clr asserted alongside a grant.
  - Response: res_valid=0 the cycle after the rst pulse. stat_cnt[0] saturates at 16'hFFFF. After stat_clr, all counters read 0.
